// File: rtl/dram_pkg.sv
// Shared definitions for the DRAM controller slice.
//   - Default data width, depth and address width of the external RAM.
//   - Read-burst FSM state encoding.
package dram_pkg;

    localparam int DRAM_WIDTH      = 32;
    localparam int DRAM_DEPTH      = 4096;
    localparam int DRAM_ADDR_WIDTH = 12;

    typedef enum logic [1:0] {
        RD_IDLE   = 2'd0,
        RD_STREAM = 2'd1,
        RD_DONE   = 2'd2
    } rd_state_e;

endpackage

// File: rtl/dram_ctrl_if.sv
// Bus bundle for dram_ctrl.
//   wr0_*/wr1_*           : two write requesters (valid/ready/addr/data)
//   rd_start/base/len     : read-burst command; rd_busy/rd_done status
//   out_valid/ready/data/last : read data stream
//   ram_*                 : external RAM port (sync write, async read)
// Modports: slave = controller side, master = requester/RAM environment side.
interface dram_ctrl_if import dram_pkg::*; #(
    parameter int RAM_WIDTH      = DRAM_WIDTH,
    parameter int RAM_ADDR_WIDTH = DRAM_ADDR_WIDTH
) ();

    logic                      wr0_valid, wr1_valid;
    logic                      wr0_ready, wr1_ready;
    logic [RAM_ADDR_WIDTH-1:0] wr0_addr,  wr1_addr;
    logic [RAM_WIDTH-1:0]      wr0_data,  wr1_data;

    logic                      rd_start;
    logic [RAM_ADDR_WIDTH-1:0] rd_base;
    logic [RAM_ADDR_WIDTH:0]   rd_len;
    logic                      rd_busy, rd_done;

    logic                      out_valid, out_ready, out_last;
    logic [RAM_WIDTH-1:0]      out_data;

    logic                      ram_wen;
    logic [RAM_ADDR_WIDTH-1:0] ram_waddr, ram_raddr;
    logic [RAM_WIDTH-1:0]      ram_din, ram_dout;

    modport slave (
        input  wr0_valid, wr1_valid, wr0_addr, wr1_addr, wr0_data, wr1_data,
        input  rd_start, rd_base, rd_len, out_ready, ram_dout,
        output wr0_ready, wr1_ready, rd_busy, rd_done,
        output out_valid, out_data, out_last,
        output ram_wen, ram_waddr, ram_din, ram_raddr
    );

    modport master (
        output wr0_valid, wr1_valid, wr0_addr, wr1_addr, wr0_data, wr1_data,
        output rd_start, rd_base, rd_len, out_ready, ram_dout,
        input  wr0_ready, wr1_ready, rd_busy, rd_done,
        input  out_valid, out_data, out_last,
        input  ram_wen, ram_waddr, ram_din, ram_raddr
    );

endinterface

// File: rtl/dram_ctrl_rr_arb2.sv
// Two-way round-robin arbiter.
//   clk, rst : clock, async active-high reset
//   req_i    : request bits, [0] = requester 0
//   gnt_o    : one-hot grant (combinational from req_i and pointer)
// The pointer names the requester that wins a tie; after any grant it
// moves to the other requester. Grants are forced off during reset.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    output logic [1:0] gnt_o
);

    logic rr_q, rr_d;

    always_comb begin
        gnt_o = 2'b00;
        if (!rst) begin
            if (req_i[0] && (!req_i[1] || !rr_q)) gnt_o = 2'b01;
            else if (req_i[1])                    gnt_o = 2'b10;
        end
    end

    always_comb begin
        rr_d = rr_q;
        if (gnt_o[0])      rr_d = 1'b1;
        else if (gnt_o[1]) rr_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) rr_q <= 1'b0;
        else     rr_q <= rr_d;
    end

endmodule

// File: rtl/dram_ctrl.sv
// DRAM controller: arbitrated dual write port plus a read-burst streamer.
//   clk, rst : clock, async active-high reset
//   bus      : dram_ctrl_if.slave (writers, burst command/status, read
//              stream, external RAM port)
// Reads use the RAM's asynchronous read port: out_data is ram_dout at the
// current burst address, so a stalled beat stays put as long as the word
// at that address is not rewritten.
module dram_ctrl import dram_pkg::*; #(
    parameter int RAM_WIDTH      = DRAM_WIDTH,
    parameter int RAM_DEPTH      = DRAM_DEPTH,
    parameter int RAM_ADDR_WIDTH = DRAM_ADDR_WIDTH
) (
    input  logic      clk,
    input  logic      rst,
    dram_ctrl_if.slave bus
);

    localparam logic [RAM_ADDR_WIDTH-1:0] ADDR_MASK = RAM_ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [RAM_ADDR_WIDTH:0]   REM_ONE   = (RAM_ADDR_WIDTH + 1)'(1);

    // ---------------- write arbitration ----------------
    logic [1:0]                gnt;
    logic [RAM_ADDR_WIDTH-1:0] waddr_mux;
    logic [RAM_WIDTH-1:0]      wdata_mux;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst   (rst),
        .req_i ({bus.wr1_valid, bus.wr0_valid}),
        .gnt_o (gnt)
    );

    always_comb begin
        waddr_mux = '0;
        wdata_mux = '0;
        if (gnt[0]) begin
            waddr_mux = bus.wr0_addr;
            wdata_mux = bus.wr0_data;
        end else if (gnt[1]) begin
            waddr_mux = bus.wr1_addr;
            wdata_mux = bus.wr1_data;
        end
    end

    assign bus.wr0_ready = gnt[0];
    assign bus.wr1_ready = gnt[1];
    assign bus.ram_wen   = |gnt;
    assign bus.ram_waddr = waddr_mux;
    assign bus.ram_din   = wdata_mux;

    // ---------------- read-burst FSM ----------------
    rd_state_e                 state_q, state_d;
    logic [RAM_ADDR_WIDTH-1:0] addr_q,  addr_d;
    logic [RAM_ADDR_WIDTH:0]   rem_q,   rem_d;
    logic                      beat;

    assign beat = (state_q == RD_STREAM) && bus.out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RD_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
        end
    end

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        case (state_q)
            RD_IDLE: begin
                if (bus.rd_start) begin
                    if (bus.rd_len != '0) begin
                        addr_d  = bus.rd_base;
                        rem_d   = bus.rd_len;
                        state_d = RD_STREAM;
                    end else begin
                        state_d = RD_DONE;
                    end
                end
            end
            RD_STREAM: begin
                if (beat) begin
                    // Mask keeps the wrap at RAM_DEPTH even if narrower than the address field.
                    addr_d = (addr_q + RAM_ADDR_WIDTH'(1)) & ADDR_MASK;
                    rem_d  = rem_q - REM_ONE;
                    if (rem_q == REM_ONE) state_d = RD_DONE;
                end
            end
            RD_DONE: state_d = RD_IDLE;
            default: state_d = RD_IDLE;
        endcase
    end

    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.out_data  = '0;
        bus.ram_raddr = '0;
        bus.rd_busy   = 1'b0;
        bus.rd_done   = 1'b0;
        case (state_q)
            RD_STREAM: begin
                bus.out_valid = 1'b1;
                bus.out_last  = (rem_q == REM_ONE);
                bus.out_data  = bus.ram_dout;
                bus.ram_raddr = addr_q;
                bus.rd_busy   = 1'b1;
            end
            RD_DONE: begin
                bus.rd_busy = 1'b1;
                bus.rd_done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dram_ctrl.sv
// Self-checking bench for dram_ctrl: external RAM model, reference memory
// image and arbitration model, directed corner cases plus a random phase.
module tb_dram_ctrl;

    localparam int W     = 32;
    localparam int AW    = 12;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dram_ctrl_if #(.RAM_WIDTH(W), .RAM_ADDR_WIDTH(AW)) bus ();

    dram_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(DEPTH), .RAM_ADDR_WIDTH(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // External RAM: sync write, async read; a bench-side preload port.
    logic [W-1:0]  mem [DEPTH];
    logic          pre_we;
    logic [AW-1:0] pre_a;
    logic [W-1:0]  pre_d;

    always @(posedge clk) begin
        if (pre_we)           mem[pre_a] <= pre_d;
        else if (bus.ram_wen) mem[bus.ram_waddr] <= bus.ram_din;
    end
    assign bus.ram_dout = mem[bus.ram_raddr];

    // Reference state
    logic [W-1:0] ref_mem [DEPTH];
    int           last_win;   // writer granted most recently (1 after reset => writer 0 wins first tie)
    int           n_vec = 0;
    int           n_err = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic wr_cycle(input bit v0, input logic [AW-1:0] a0, input logic [W-1:0] d0,
                            input bit v1, input logic [AW-1:0] a1, input logic [W-1:0] d1,
                            output bit g0, output bit g1);
        int win;
        @(negedge clk);
        bus.wr0_valid = v0; bus.wr0_addr = a0; bus.wr0_data = d0;
        bus.wr1_valid = v1; bus.wr1_addr = a1; bus.wr1_data = d1;
        #1;
        // A lone requester wins; a tie goes to whoever did not win last.
        if (v0 && v1)  win = 1 - last_win;
        else if (v0)   win = 0;
        else if (v1)   win = 1;
        else           win = -1;
        g0 = (win == 0);
        g1 = (win == 1);
        chk("wr0_ready", bus.wr0_ready, g0);
        chk("wr1_ready", bus.wr1_ready, g1);
        chk("ram_wen",   bus.ram_wen,   g0 | g1);
        if (win == 0) begin
            chk("ram_waddr", bus.ram_waddr, a0); chk("ram_din", bus.ram_din, d0);
            ref_mem[a0] = d0;
        end else if (win == 1) begin
            chk("ram_waddr", bus.ram_waddr, a1); chk("ram_din", bus.ram_din, d1);
            ref_mem[a1] = d1;
        end else begin
            chk("ram_waddr_idle", bus.ram_waddr, 0);
        end
        if (win >= 0) last_win = win;
    endtask

    task automatic wr_idle();
        @(negedge clk);
        bus.wr0_valid = 1'b0;
        bus.wr1_valid = 1'b0;
    endtask

    // One burst; out_ready from pattern (bit per cycle) or random.
    // poke keeps rd_start asserted with junk while streaming.
    task automatic rd_burst(input logic [AW-1:0] base, input logic [AW:0] len,
                            input bit use_pat, input logic [7:0] pat, input bit poke);
        int            idx, cyc;
        logic [AW-1:0] a;
        @(negedge clk);
        bus.rd_start = 1'b1; bus.rd_base = base; bus.rd_len = len; bus.out_ready = 1'b0;
        #1;
        chk("idle_busy", bus.rd_busy, 0);
        chk("idle_raddr", bus.ram_raddr, 0);
        idx = 0; cyc = 0;
        while (idx < int'(len) && cyc < 100) begin
            @(negedge clk);
            bus.rd_start = poke;
            if (poke) begin
                bus.rd_base = AW'($urandom);
                bus.rd_len  = (AW+1)'(1);
            end
            bus.out_ready = use_pat ? pat[cyc % 8] : ($urandom_range(0, 3) != 0);
            #1;
            a = AW'((int'(base) + idx) % DEPTH);
            chk("out_valid", bus.out_valid, 1);
            chk("out_data",  bus.out_data,  ref_mem[a]);
            chk("out_last",  bus.out_last,  idx == int'(len) - 1);
            chk("busy_strm", bus.rd_busy,   1);
            chk("done_strm", bus.rd_done,   0);
            if (bus.out_ready) idx++;
            cyc++;
        end
        if (cyc >= 100) chk("burst_timeout", 0, 1);
        @(negedge clk);
        bus.rd_start = 1'b0; bus.out_ready = 1'($urandom);
        #1;
        chk("rd_done",    bus.rd_done,   1);
        chk("valid_done", bus.out_valid, 0);
        chk("busy_done",  bus.rd_busy,   1);
        @(negedge clk); #1;
        chk("done_clr",   bus.rd_done,   0);
        chk("busy_clr",   bus.rd_busy,   0);
        chk("valid_idle", bus.out_valid, 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit g0, g1;
        int i0, i1;
        logic [W-1:0] oldw, neww;

        rst = 1'b1; pre_we = 1'b0; pre_a = '0; pre_d = '0;
        bus.wr0_valid = 1'b1; bus.wr1_valid = 1'b1;
        bus.wr0_addr = '0; bus.wr1_addr = '0; bus.wr0_data = '0; bus.wr1_data = '0;
        bus.rd_start = 1'b1; bus.rd_base = '0; bus.rd_len = (AW+1)'(3); bus.out_ready = 1'b1;
        last_win = 1;

        // Reset state with requests present
        @(negedge clk); #1;
        chk("rst_wr0_ready", bus.wr0_ready, 0);
        chk("rst_wr1_ready", bus.wr1_ready, 0);
        chk("rst_ram_wen",   bus.ram_wen,   0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last",  bus.out_last,  0);
        chk("rst_busy",      bus.rd_busy,   0);
        chk("rst_done",      bus.rd_done,   0);
        bus.wr0_valid = 1'b0; bus.wr1_valid = 1'b0; bus.rd_start = 1'b0;

        // Preload RAM under reset
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            pre_we = 1'b1; pre_a = AW'(i); pre_d = $urandom;
            ref_mem[i] = pre_d;
        end
        @(negedge clk);
        pre_we = 1'b0;
        rst = 1'b0;

        // Both writers held valid: grants alternate 0,1,0,1
        i0 = 0; i1 = 0;
        for (int k = 0; k < 4; k++) begin
            wr_cycle(1'b1, AW'(i0), 32'hDA00_0000 + k, 1'b1, AW'(100 + i1), 32'hDB00_0000 + k, g0, g1);
            chk("alt_grant0", g0, (k % 2) == 0);
            if (g0) i0++;
            if (g1) i1++;
        end
        wr_idle();
        chk("ram0",   mem[0],   32'hDA00_0000);
        chk("ram100", mem[100], 32'hDB00_0001);
        chk("ram1",   mem[1],   32'hDA00_0002);
        chk("ram101", mem[101], 32'hDB00_0003);

        // A..D at 10..13, full-rate burst
        for (int k = 0; k < 4; k++)
            wr_cycle(1'b0, '0, '0, 1'b1, AW'(10 + k), 32'hA0A0_0000 + k, g0, g1);
        wr_idle();
        rd_burst(AW'(10), (AW+1)'(4), 1'b1, 8'hFF, 1'b0);

        // Address wrap
        rd_burst(AW'(4094), (AW+1)'(4), 1'b1, 8'hFF, 1'b0);
        // Stall pattern 1,0,0,1,1
        rd_burst(AW'(50), (AW+1)'(3), 1'b1, 8'b0001_1001, 1'b0);
        // Zero length
        rd_burst(AW'(20), (AW+1)'(0), 1'b1, 8'hFF, 1'b0);
        // rd_start during stream ignored
        rd_burst(AW'(30), (AW+1)'(5), 1'b0, 8'h00, 1'b1);

        // Same-cycle write to the address being streamed
        @(negedge clk);
        bus.rd_start = 1'b1; bus.rd_base = AW'(300); bus.rd_len = (AW+1)'(1); bus.out_ready = 1'b0;
        oldw = ref_mem[300];
        neww = ~oldw;
        @(negedge clk);
        bus.rd_start = 1'b0;
        bus.wr0_valid = 1'b1; bus.wr0_addr = AW'(300); bus.wr0_data = neww;
        #1;
        chk("raw_grant",    bus.wr0_ready, 1);
        chk("raw_old_data", bus.out_data,  oldw);
        last_win = 0;
        ref_mem[300] = neww;
        @(negedge clk);
        bus.wr0_valid = 1'b0; bus.out_ready = 1'b1;
        #1;
        chk("raw_new_data", bus.out_data, neww);
        chk("raw_last",     bus.out_last, 1);
        @(negedge clk);
        bus.out_ready = 1'b0;
        #1;
        chk("raw_done", bus.rd_done, 1);
        @(negedge clk);

        // Reset mid-burst after 2 of 8 beats
        @(negedge clk);
        bus.rd_start = 1'b1; bus.rd_base = AW'(500); bus.rd_len = (AW+1)'(8); bus.out_ready = 1'b1;
        @(negedge clk); bus.rd_start = 1'b0;
        @(negedge clk);
        @(negedge clk); #1;
        chk("pre_rst_data", bus.out_data, ref_mem[502]);
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_done",  bus.rd_done,   0);
        chk("mid_rst_busy",  bus.rd_busy,   0);
        last_win = 1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_done",  bus.rd_done,   0);
        chk("post_rst_valid", bus.out_valid, 0);
        rd_burst(AW'(0), (AW+1)'(2), 1'b1, 8'hFF, 1'b0);

        // Random phase
        for (int it = 0; it < 40; it++) begin
            int nw;
            nw = $urandom_range(0, 6);
            for (int k = 0; k < nw; k++)
                wr_cycle(1'($urandom), AW'($urandom_range(0, 63)), $urandom,
                         1'($urandom), AW'($urandom_range(4088, 4095)), $urandom, g0, g1);
            wr_idle();
            if ($urandom_range(0, 1) == 0)
                rd_burst(AW'($urandom_range(0, 60)), (AW+1)'($urandom_range(0, 9)), 1'b0, 8'h00, 1'($urandom));
            else
                rd_burst(AW'($urandom_range(4086, 4095)), (AW+1)'($urandom_range(0, 9)), 1'b0, 8'h00, 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dram_ctrl.md
DRAM_CTRL -- requirements
Module: dram_ctrl

Interface
REQ-001 SHALL have parameter RAM_WIDTH, default 32, meaning data word width.
REQ-002 SHALL have parameter RAM_DEPTH, default 4096, meaning number of RAM words.
REQ-003 SHALL have parameter RAM_ADDR_WIDTH, default 12, meaning address width.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all logic is on posedge clk.
REQ-005 SHALL have port rst, input, 1 bit, reset; it is asynchronous and active-high.
REQ-006 SHALL have ports wr0_valid, wr1_valid, input, 1 bit each, meaning the write request from requester 0 or 1.
REQ-007 SHALL have ports wr0_ready, wr1_ready, output, 1 bit each, meaning the write grant.
REQ-008 SHALL have ports wr0_addr, wr1_addr, input, RAM_ADDR_WIDTH bits, meaning the write address.
REQ-009 SHALL have ports wr0_data, wr1_data, input, RAM_WIDTH bits, meaning the write data.
REQ-010 SHALL have ports rd_start (input, 1), rd_base (input, RAM_ADDR_WIDTH) and rd_len (input, RAM_ADDR_WIDTH+1), meaning the read-burst command.
REQ-011 SHALL have ports rd_busy (output, 1) and rd_done (output, 1), meaning burst status.
REQ-012 SHALL have ports out_valid (output, 1), out_ready (input, 1), out_data (output, RAM_WIDTH) and out_last (output, 1), meaning the read stream.
REQ-013 SHALL have ports ram_wen (output, 1), ram_waddr (output, RAM_ADDR_WIDTH), ram_din (output, RAM_WIDTH), ram_raddr (output, RAM_ADDR_WIDTH) and ram_dout (input, RAM_WIDTH), meaning the RAM port; the RAM has synchronous write and asynchronous read.

Function
REQ-014 SHALL grant at most one writer per cycle; the grant is combinational from the valids and a registered round-robin pointer rr.
REQ-015 SHALL grant the sole valid writer when only one is valid; when both are valid it SHALL grant the writer indicated by rr.
REQ-016 SHALL toggle rr to point away from the granted writer after every grant, so that the next contended cycle goes to the other writer.
REQ-017 SHALL drive ram_wen = wr0_ready|wr1_ready, with ram_waddr and ram_din muxed combinationally from the granted writer (zero when there is no grant).
REQ-018 SHALL implement the read FSM states IDLE, STREAM and DONE.
REQ-019 In IDLE with rd_start=1 and rd_len!=0, SHALL capture rd_base into addr and rd_len into the remaining count rem, then go to STREAM.
REQ-020 In IDLE with rd_start=1 and rd_len==0, SHALL go to DONE with no beats.
REQ-021 SHALL ignore rd_start in STREAM and DONE; no queuing.
REQ-022 In STREAM, SHALL drive out_valid=1, ram_raddr=addr, out_data=ram_dout (combinational) and out_last=(rem==1).
REQ-023 On out_valid&out_ready, SHALL set addr<=addr+1 (wrapping modulo RAM_DEPTH, RAM_DEPTH a power of two) and rem<=rem-1, and go to DONE when rem==1.
REQ-024 While out_ready=0, SHALL hold out_data, out_last and addr stable, provided the RAM content at addr is unchanged.
REQ-025 DONE SHALL last exactly one cycle, with rd_done=1 for that cycle, then go to IDLE.
REQ-026 SHALL drive rd_busy=1 in STREAM and DONE.
REQ-027 Latency: the first beat SHALL appear the cycle after rd_start is accepted; with out_ready held high there is one beat per cycle.
REQ-028 Writes and reads SHALL be independent; on a same-cycle write to addr, out_data shows the old word and the new word from the next cycle.
REQ-029 SHALL drive ram_raddr=0 outside STREAM.

Reset
REQ-030 On rst, SHALL asynchronously set state=IDLE, addr=0, rem=0 and rr=0 (requester 0 first).
REQ-031 Outputs under reset SHALL be: wr*_ready=0, ram_wen=0, out_valid=0, out_last=0, rd_busy=0, rd_done=0.
REQ-032 Reset mid-burst SHALL abort the burst with no rd_done, and the next burst SHALL start cleanly.

Structure
REQ-033 SHALL put the FSM state encoding (IDLE, STREAM, DONE) in shared package dram_pkg.
REQ-034 SHALL put the default width and depth constants in shared package dram_pkg.
REQ-035 SHALL implement the write arbiter as sub-module rr_arb2 (2 requests, registered pointer, one-hot grant).
REQ-036 Read FSM and datapath SHALL be inline; the RAM is external to dram_ctrl.

Verification
REQ-037 Both writers held valid for 4 cycles (wr0 addr 0..3, wr1 addr 100..103) -> grants alternate 0,1,0,1; RAM[0]=d0, RAM[100]=d1, RAM[1]=d2, RAM[101]=d3.
REQ-038 Preload RAM[10..13]=A..D, rd_start base=10 len=4, out_ready=1 -> beats A,B,C,D on 4 consecutive cycles, out_last on D, rd_done the next cycle.
REQ-039 Base=4094, len=4 -> data from addresses 4094, 4095, 0, 1.
REQ-040 Stream len=3 with out_ready toggling 1,0,0,1,1 -> exactly 3 beats, data stable while stalled, no duplicates.
REQ-041 rd_len=0 -> rd_done one cycle after start, out_valid never 1; rd_start during STREAM -> ignored.
REQ-042 rst asserted mid-burst (after 2 of 8 beats) -> out_valid=0 immediately, no rd_done; a new burst base=0 len=2 then completes normally.
